// File: rtl/ble_lut4_cfg_if.sv
// Serial configuration port of the BLE: frame start, bit stream, and load status/scan-out.
// Handshake: cfg_bit is consumed on every rising edge where cfg_valid=1 while a frame is loading;
// there is no ready/backpressure, cfg_valid outside a load is ignored, and cfg_start wins over cfg_valid.
interface ble_lut4_cfg_if;
    logic cfg_start;
    logic cfg_valid;
    logic cfg_bit;
    logic cfg_busy;
    logic cfg_done;
    logic cfg_so;

    modport master (
        output cfg_start, cfg_valid, cfg_bit,
        input  cfg_busy, cfg_done, cfg_so
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_bit,
        output cfg_busy, cfg_done, cfg_so
    );
endinterface

// File: rtl/ble_lut4_cfg.sv
// Basic logic element: 4-input LUT plus optional D flip-flop, both programmed through a
// serial shadow register that commits atomically and scans its old contents out on cfg_so.
module ble_lut4_cfg #(
    parameter int LUT_K  = 4,
    parameter int INIT_W = 16,
    parameter int CFG_W  = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    ble_lut4_cfg_if.slave     cfg,
    input  logic              A,
    input  logic              B,
    input  logic              C,
    input  logic              D,
    input  logic              ce,
    output logic              X,
    output logic [1:0]        dbg_state
);
    localparam int CNT_W = $clog2(CFG_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_W - 1);

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CFG_W-1:0] shadow_q;
    logic [CFG_W-1:0] active_q;
    logic [CNT_W-1:0] cnt_q;
    logic             so_q;
    logic             done_q;
    logic             q_q;
    logic             restart;
    logic             shift_en;
    logic             commit;
    logic [LUT_K-1:0] idx;
    logic [INIT_W-1:0] init;
    logic             lut;
    logic             ff_sel;

    assign idx    = {A, B, C, D};
    assign init   = active_q[INIT_W-1:0];
    assign lut    = init[idx];
    assign ff_sel = active_q[CFG_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNCONF;
        end else begin
            state_q <= state_d;
        end
    end

    // cfg_start takes priority over a coincident cfg_valid, so that bit is dropped.
    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        shift_en = 1'b0;
        commit   = 1'b0;
        case (state_q)
            UNCONF: begin
                if (cfg.cfg_start) begin
                    state_d = LOAD;
                    restart = 1'b1;
                end
            end
            LOAD: begin
                if (cfg.cfg_start) begin
                    restart = 1'b1;
                end else if (cfg.cfg_valid) begin
                    shift_en = 1'b1;
                    if (cnt_q == LAST) begin
                        commit  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (cfg.cfg_start) begin
                    state_d = LOAD;
                    restart = 1'b1;
                end
            end
            default: state_d = UNCONF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            so_q     <= 1'b0;
            done_q   <= 1'b0;
            q_q      <= 1'b0;
        end else begin
            done_q <= commit;
            if (restart) begin
                cnt_q <= '0;
            end else if (shift_en) begin
                cnt_q <= commit ? '0 : cnt_q + 1'b1;
            end
            if (shift_en) begin
                shadow_q <= {cfg.cfg_bit, shadow_q[CFG_W-1:1]};
                so_q     <= shadow_q[0];
            end
            if (commit) begin
                active_q <= {cfg.cfg_bit, shadow_q[CFG_W-1:1]};
            end
            // The flop keeps running on the old function while a reload is in progress.
            if (commit) begin
                q_q <= 1'b0;
            end else if (ff_sel && ce) begin
                q_q <= lut;
            end
        end
    end

    assign X            = (state_q == UNCONF) ? 1'b0 : (ff_sel ? q_q : lut);
    assign cfg.cfg_busy = (state_q == LOAD);
    assign cfg.cfg_done = done_q;
    assign cfg.cfg_so   = so_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_ble_lut4_cfg.sv
// Directed bench for ble_lut4_cfg: LUT vector table, flop mode, reload, restart, reset and scan chain.
module tb_ble_lut4_cfg;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       A, B, C, D, ce;
    logic       X;
    logic [1:0] dbg_state;

    ble_lut4_cfg_if cfg_if ();

    ble_lut4_cfg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cfg_if.slave),
        .A         (A),
        .B         (B),
        .C         (C),
        .D         (D),
        .ce        (ce),
        .X         (X),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] init;
        logic [3:0]  abcd;
        logic        exp_x;
    } vec_t;

    vec_t        vecs[14];
    logic [0:0]  exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    logic [15:0] loaded;

    always @(negedge clk) if (cfg_if.cfg_done) done_cnt++;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abcd(input logic [3:0] v);
        {A, B, C, D} = v;
    endtask

    task automatic start_frame();
        cfg_if.cfg_start = 1'b1;
        tick();
        cfg_if.cfg_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_bit   = b;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] init, input logic ff);
        for (int i = 0; i < 16; i++) send_bit(init[i]);
        send_bit(ff);
        check("done_pulse", cfg_if.cfg_done, 1'b1);
        check("busy_after_commit", cfg_if.cfg_busy, 1'b0);
        tick();
        check("done_one_cycle", cfg_if.cfg_done, 1'b0);
        loaded = init;
    endtask

    task automatic send_frame(input logic [15:0] init, input logic ff);
        start_frame();
        send_bits(init, ff);
    endtask

    // Loads a frame while comparing cfg_so against exp_q, with idle gaps that must stall the stream.
    task automatic chain_frame(input logic [16:0] v);
        logic held;
        start_frame();
        for (int i = 0; i < 17; i++) begin
            send_bit(v[i]);
            check("so_stream", cfg_if.cfg_so, exp_q.pop_front());
            if (i % 4 == 3) begin
                held = cfg_if.cfg_so;
                tick();
                check("so_gap_hold", cfg_if.cfg_so, held);
            end
        end
        tick();
    endtask

    initial begin
        logic [16:0] pvec;
        logic [15:0] or_init;
        int          d0;

        vecs[0]  = '{16'h8000, 4'hF, 1'b1};
        vecs[1]  = '{16'h8000, 4'hE, 1'b0};
        vecs[2]  = '{16'h8000, 4'h7, 1'b0};
        vecs[3]  = '{16'h6996, 4'h0, 1'b0};
        vecs[4]  = '{16'h6996, 4'h1, 1'b1};
        vecs[5]  = '{16'h6996, 4'h3, 1'b0};
        vecs[6]  = '{16'h6996, 4'h7, 1'b1};
        vecs[7]  = '{16'h6996, 4'hF, 1'b0};
        vecs[8]  = '{16'hFFFE, 4'h0, 1'b0};
        vecs[9]  = '{16'hFFFE, 4'hA, 1'b1};
        vecs[10] = '{16'hCAFE, 4'h0, 1'b0};
        vecs[11] = '{16'hCAFE, 4'h9, 1'b1};
        vecs[12] = '{16'hCAFE, 4'hC, 1'b0};
        vecs[13] = '{16'hCAFE, 4'hE, 1'b1};

        // Clock/reset
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_bit   = 1'b0;
        ce = 1'b0;
        set_abcd(4'hF);
        loaded = 16'h0000;
        tick();
        tick();
        check("rst_x", X, 1'b0);
        check("rst_busy", cfg_if.cfg_busy, 1'b0);
        check("rst_done", cfg_if.cfg_done, 1'b0);
        check("rst_so", cfg_if.cfg_so, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("unconf_x", X, 1'b0);

        // AND4 load from UNCONF, X held low throughout the load
        start_frame();
        check("busy_rise", cfg_if.cfg_busy, 1'b1);
        pvec = {1'b0, 16'h8000};
        for (int i = 0; i < 17; i++) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_bit   = pvec[i];
            #1;
            check("x_load_unconf", X, 1'b0);
            tick();
        end
        cfg_if.cfg_valid = 1'b0;
        check("commit_done", cfg_if.cfg_done, 1'b1);
        check("commit_state", dbg_state, 2'd2);
        tick();
        check("commit_done_low", cfg_if.cfg_done, 1'b0);
        loaded = 16'h8000;
        for (int i = 0; i < 16; i++) begin
            set_abcd(4'(i));
            #1;
            check("and4_sweep", X, (i == 15) ? 1'b1 : 1'b0);
        end

        // Combinational vector table
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].init !== loaded) send_frame(vecs[i].init, 1'b0);
            set_abcd(vecs[i].abcd);
            #1;
            check("lut_vec", X, vecs[i].exp_x);
        end

        // Registered XOR4 with clock enable
        send_frame(16'h6996, 1'b1);
        check("ff_cleared", X, 1'b0);
        ce = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_abcd(4'(i));
            exp_q.push_back(^(4'(i)));
            tick();
            check("ff_parity", X, exp_q.pop_front());
        end
        ce = 1'b0;
        set_abcd(4'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce_freeze", X, 1'b0);
        end
        ce = 1'b1;
        tick();
        check("ce_resume", X, 1'b1);
        ce = 1'b0;

        // Reload AND4 -> OR4 with inputs toggling; old function stays live until commit
        send_frame(16'h8000, 1'b0);
        start_frame();
        or_init = 16'hFFFE;
        for (int i = 0; i < 17; i++) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_bit   = (i < 16) ? or_init[i] : 1'b0;
            set_abcd(4'((i * 7) % 16));
            #1;
            check("x_old_and4", X, {A, B, C, D} == 4'hF);
            check("busy_window", cfg_if.cfg_busy, 1'b1);
            tick();
        end
        cfg_if.cfg_valid = 1'b0;
        check("reload_done", cfg_if.cfg_done, 1'b1);
        for (int i = 0; i < 4; i++) begin
            set_abcd(4'(i * 5));
            #1;
            check("x_new_or4", X, (i != 0) ? 1'b1 : 1'b0);
        end
        tick();

        // Restart after 9 bits; the restart coincides with a valid bit that must be dropped
        d0 = done_cnt;
        start_frame();
        for (int i = 0; i < 9; i++) send_bit(1'b1);
        cfg_if.cfg_start = 1'b1;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_bit   = 1'b1;
        tick();
        cfg_if.cfg_start = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        check("restart_busy", cfg_if.cfg_busy, 1'b1);
        send_bits(16'h0001, 1'b0);
        check("restart_one_done", done_cnt - d0, 1);
        for (int i = 0; i < 16; i++) begin
            set_abcd(4'(i));
            #1;
            check("nor4_sweep", X, (i == 0) ? 1'b1 : 1'b0);
        end

        // Asynchronous reset in the middle of a frame
        start_frame();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        set_abcd(4'h0);
        #1;
        check("x_before_reset", X, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_x", X, 1'b0);
        check("rst_mid_busy", cfg_if.cfg_busy, 1'b0);
        check("rst_mid_state", dbg_state, 2'd0);
        check("rst_mid_so", cfg_if.cfg_so, 1'b0);
        #2;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1);
            check("ignored_busy", cfg_if.cfg_busy, 1'b0);
            check("ignored_so", cfg_if.cfg_so, 1'b0);
            check("ignored_x", X, 1'b0);
        end

        // Scan chain: first frame drains the reset shadow, second drains pattern P in order
        for (int i = 0; i < 17; i++) exp_q.push_back(1'b0);
        pvec = {1'b1, 16'hA5C3};
        chain_frame(pvec);
        for (int i = 0; i < 17; i++) exp_q.push_back(pvec[i]);
        chain_frame({1'b0, 16'h0F0F});
        check("chain_queue_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
